register_file_wb: RTL and testbench

//  Receiving end of the writeback path: the 32-entry integer register file that accepts

---
 rtl/register_file_wb_pkg.sv | 15 +
 rtl/register_file_wb_scoreboard.sv | 54 +++++
 rtl/register_file_wb.sv | 72 +++++++
 tb/tb_register_file_wb.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/register_file_wb_pkg.sv
// rtl/register_file_wb_pkg.sv - shared sizes, zero-register index and writeback select codes
// Imported by register file and scoreboard so producer and sink agree on encodings.
package register_file_wb_pkg;

  localparam int DEF_DATA_SIZE = 32;
  localparam int DEF_ADDR_SIZE = 5;
  localparam int REG_ZERO      = 0;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'b00,
    WB_SEL_DM  = 2'b01,
    WB_SEL_REG = 2'b10
  } wb_sel_e;

endpackage

// File: rtl/register_file_wb_scoreboard.sv
// rtl/register_file_wb_scoreboard.sv - per-register busy vector with pending count
// Set (reserve) wins over clear (writeback) on the same index; register 0 is never busy.
module wb_scoreboard
  import register_file_wb_pkg::*;
#(
  parameter int AddrSize = DEF_ADDR_SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_en_i,
  input  logic [AddrSize-1:0]    set_idx_i,
  input  logic                   clr_en_i,
  input  logic [AddrSize-1:0]    clr_idx_i,
  output logic [2**AddrSize-1:0] busy_o,
  output logic [AddrSize:0]      count_o
);

  localparam logic [AddrSize-1:0] Zero = AddrSize'(REG_ZERO);

  logic [2**AddrSize-1:0] busy_q, busy_d;
  logic [AddrSize:0]      count_q, count_d;
  logic                   set_new, clr_old;

  // Count is tracked incrementally: +1 for a fresh reservation, -1 for a real release.
  always_comb begin
    busy_d  = busy_q;
    set_new = 1'b0;
    clr_old = 1'b0;
    if (clr_en_i && clr_idx_i != Zero) begin
      clr_old           = busy_q[clr_idx_i];
      busy_d[clr_idx_i] = 1'b0;
    end
    if (set_en_i && set_idx_i != Zero) begin
      set_new           = ~busy_q[set_idx_i];
      busy_d[set_idx_i] = 1'b1;
      if (clr_en_i && clr_idx_i == set_idx_i) clr_old = 1'b0;
    end
    count_d = count_q + {{AddrSize{1'b0}}, set_new} - {{AddrSize{1'b0}}, clr_old};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_o  = busy_q;
  assign count_o = count_q;

endmodule

// File: rtl/register_file_wb.sv
// rtl/register_file_wb.sv - 32-entry register file with busy scoreboard, two read ports
// Optional same-cycle write-to-read forwarding when WB_BYPASS_EN is defined.
module register_file_wb
  import register_file_wb_pkg::*;
#(
  parameter int DataSize = DEF_DATA_SIZE,
  parameter int AddrSize = DEF_ADDR_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AddrSize-1:0] read_reg1,
  input  logic [AddrSize-1:0] read_reg2,
  output logic [DataSize-1:0] read_data1,
  output logic [DataSize-1:0] read_data2,
  output logic                busy1,
  output logic                busy2,
  input  logic                write_enable,
  input  logic [AddrSize-1:0] write_reg,
  input  logic [DataSize-1:0] write_data,
  input  logic                reserve_enable,
  input  logic [AddrSize-1:0] reserve_reg,
  output logic [AddrSize:0]   pending_count
);

  localparam int RegCount = 2**AddrSize;
  localparam logic [AddrSize-1:0] Zero = AddrSize'(REG_ZERO);

  logic [DataSize-1:0] regs_q [RegCount];
  logic [RegCount-1:0] busy_vec;
  logic                wr_ok;

  assign wr_ok = write_enable && (write_reg != Zero);

  // Entry 0 is cleared by reset and never written, so it always reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RegCount; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[write_reg] <= write_data;
    end
  end

  wb_scoreboard #(.AddrSize(AddrSize)) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en_i  (reserve_enable),
    .set_idx_i (reserve_reg),
    .clr_en_i  (write_enable),
    .clr_idx_i (write_reg),
    .busy_o    (busy_vec),
    .count_o   (pending_count)
  );

`ifdef WB_BYPASS_EN
  logic byp1, byp2, rsv1, rsv2;
  assign byp1 = wr_ok && (write_reg == read_reg1);
  assign byp2 = wr_ok && (write_reg == read_reg2);
  assign rsv1 = reserve_enable && (reserve_reg == read_reg1);
  assign rsv2 = reserve_enable && (reserve_reg == read_reg2);

  assign read_data1 = byp1 ? write_data : regs_q[read_reg1];
  assign read_data2 = byp2 ? write_data : regs_q[read_reg2];
  assign busy1      = byp1 ? rsv1 : busy_vec[read_reg1];
  assign busy2      = byp2 ? rsv2 : busy_vec[read_reg2];
`else
  assign read_data1 = regs_q[read_reg1];
  assign read_data2 = regs_q[read_reg2];
  assign busy1      = busy_vec[read_reg1];
  assign busy2      = busy_vec[read_reg2];
`endif

endmodule

// File: tb/tb_register_file_wb.sv
// tb/tb_register_file_wb.sv - directed and random checks of register_file_wb against a reference model
// Model follows the architectural rules (array of values, array of busy flags); honours WB_BYPASS_EN.
module tb_register_file_wb;

  logic        clk;
  logic        rst;
  logic [4:0]  read_reg1, read_reg2, write_reg, reserve_reg;
  logic [31:0] read_data1, read_data2, write_data;
  logic        busy1, busy2, write_enable, reserve_enable;
  logic [5:0]  pending_count;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];

  register_file_wb dut (
    .clk            (clk),
    .rst            (rst),
    .read_reg1      (read_reg1),
    .read_reg2      (read_reg2),
    .read_data1     (read_data1),
    .read_data2     (read_data2),
    .busy1          (busy1),
    .busy2          (busy2),
    .write_enable   (write_enable),
    .write_reg      (write_reg),
    .write_data     (write_data),
    .reserve_enable (reserve_enable),
    .reserve_reg    (reserve_reg),
    .pending_count  (pending_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_data(input logic [4:0] r);
    if (r == 0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (write_enable && write_reg == r) return write_data;
`endif
    return m_regs[r];
  endfunction

  function automatic logic exp_busy(input logic [4:0] r);
    if (r == 0) return 1'b0;
`ifdef WB_BYPASS_EN
    if (write_enable && write_reg == r) return reserve_enable && reserve_reg == r;
`endif
    return m_busy[r];
  endfunction

  function automatic logic [5:0] exp_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return 6'(c);
  endfunction

  task automatic step(input string tag, input bit chk, input logic r,
                      input logic we, input logic [4:0] wr, input logic [31:0] wd,
                      input logic re, input logic [4:0] rr,
                      input logic [4:0] a, input logic [4:0] b);
    logic [31:0] e_d1, e_d2;
    logic        e_b1, e_b2;
    logic [5:0]  e_c;
    rst = r; write_enable = we; write_reg = wr; write_data = wd;
    reserve_enable = re; reserve_reg = rr; read_reg1 = a; read_reg2 = b;
    #1;
    if (chk) begin
      e_d1 = exp_data(a); e_d2 = exp_data(b);
      e_b1 = exp_busy(a); e_b2 = exp_busy(b);
      e_c  = exp_count();
      n_chk++;
      assert (read_data1 === e_d1) else begin
        n_fail++; $error("FAIL %s read_data1 r%0d got=%h exp=%h", tag, a, read_data1, e_d1);
      end
      n_chk++;
      assert (read_data2 === e_d2) else begin
        n_fail++; $error("FAIL %s read_data2 r%0d got=%h exp=%h", tag, b, read_data2, e_d2);
      end
      n_chk++;
      assert (busy1 === e_b1) else begin
        n_fail++; $error("FAIL %s busy1 r%0d got=%b exp=%b", tag, a, busy1, e_b1);
      end
      n_chk++;
      assert (busy2 === e_b2) else begin
        n_fail++; $error("FAIL %s busy2 r%0d got=%b exp=%b", tag, b, busy2, e_b2);
      end
      n_chk++;
      assert (pending_count === e_c) else begin
        n_fail++; $error("FAIL %s pending_count got=%0d exp=%0d", tag, pending_count, e_c);
      end
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = 32'h0; m_busy[i] = 1'b0; end
    end else begin
      if (we && wr != 0) begin m_regs[wr] = wd; m_busy[wr] = 1'b0; end
      if (re && rr != 0) m_busy[rr] = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_regs[i] = 32'h0; m_busy[i] = 1'b0; end

    step("init_rst", 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    step("rst_state", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd31);

    // Preload, then reset must wipe data and reservations
    step("pre_w1", 1'b1, 1'b0, 1'b1, 5'd1, 32'h1111_2222, 1'b1, 5'd10, 5'd1, 5'd10);
    step("pre_w2", 1'b1, 1'b0, 1'b1, 5'd2, 32'h3333_4444, 1'b1, 5'd11, 5'd1, 5'd2);
    step("pre_rd", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd11);
    step("rst_pulse", 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd2);
    step("post_rst", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd10);

    step("w_r5", 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 5'd0);
    step("rd_r5", 1'b1, 1'b0, 1'b1, 5'd0, 32'h0000_0001, 1'b1, 5'd0, 5'd5, 5'd5);
    step("rd_r0", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5);

    step("rsv_r7", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd9);
    step("rsv_r9", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd7, 5'd9);
    step("rsv_again", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd7, 5'd9);
    step("w_r7", 1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0777, 1'b0, 5'd0, 5'd7, 5'd9);
    step("w_r3", 1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0333, 1'b0, 5'd0, 5'd7, 5'd3);
    step("chk_r3", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd9);

    step("rsv_w_r4", 1'b1, 1'b0, 1'b1, 5'd4, 32'h0000_0012, 1'b1, 5'd4, 5'd4, 5'd9);
    step("chk_r4", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd4);
    step("rsv_w_r9", 1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_0099, 1'b1, 5'd9, 5'd9, 5'd4);
    step("w9_rsv12", 1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_0999, 1'b1, 5'd12, 5'd9, 5'd12);

    step("w_r6_byp", 1'b1, 1'b0, 1'b1, 5'd6, 32'hA5A5_A5A5, 1'b0, 5'd0, 5'd1, 5'd6);
    step("w6_rsv6", 1'b1, 1'b0, 1'b1, 5'd6, 32'h5A5A_5A5A, 1'b1, 5'd6, 5'd6, 5'd6);
    step("chk_r6", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd6, 5'd12);

    step("rst_w_r8", 1'b1, 1'b1, 1'b1, 5'd8, 32'hFFFF_0008, 1'b1, 5'd8, 5'd8, 5'd6);
    step("chk_r8", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd8, 5'd6);

    for (int n = 0; n < 400; n++) begin
      logic        we, re, rr_rst;
      logic [4:0]  wr, rr, a, b;
      logic [31:0] wd;
      we     = 1'($urandom_range(0, 1));
      re     = ($urandom_range(0, 2) == 0);
      rr_rst = ($urandom_range(0, 79) == 0);
      wr     = 5'($urandom_range(0, 31));
      rr     = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      wd     = $urandom;
      a      = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      b      = ($urandom_range(0, 2) == 0) ? rr : 5'($urandom_range(0, 31));
      step("random", 1'b1, rr_rst, we, wr, wd, re, rr, a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
